// File: rtl/otter_fetch_queue_if.sv
// Fetch/decode/memory signal bundle for otter_fetch_queue.
// The queue side uses the master modport and its environment uses the slave modport.
interface otter_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            REDIRECT;
    logic [XLEN-1:0] REDIRECT_PC;
    logic            MEM_RDEN1;
    logic [XLEN-1:0] FETCH_PC;
    logic [31:0]     MEM_DOUT1;
    logic            DE_READY;
    logic            DE_VALID;
    logic [31:0]     DE_IR;
    logic [XLEN-1:0] DE_PC;
    logic [CW-1:0]   COUNT;

    modport master (
        input  REDIRECT, REDIRECT_PC, MEM_DOUT1, DE_READY,
        output MEM_RDEN1, FETCH_PC, DE_VALID, DE_IR, DE_PC, COUNT
    );

    modport slave (
        output REDIRECT, REDIRECT_PC, MEM_DOUT1, DE_READY,
        input  MEM_RDEN1, FETCH_PC, DE_VALID, DE_IR, DE_PC, COUNT
    );
endinterface

// File: rtl/otter_fetch_queue.sv
// Instruction fetch queue: issues sequential reads, buffers {IR, PC} in a circular FIFO
// and hands the head to decode. A redirect flushes the queue and any response in flight.
module otter_fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                CLK,
    input  logic                RESET,
    otter_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic [31:0]     ir_mem [DEPTH];
    logic [XLEN-1:0] pc_mem [DEPTH];

    logic            pop_s;
    logic            push_s;
    logic            rden_s;
    logic [CW:0]     occupancy_s;

    // Handshake decisions; an in-flight response reserves a slot so the queue cannot overflow.
    always_comb begin
        pop_s       = (count_q != {CW{1'b0}}) && bus.DE_READY && !bus.REDIRECT;
        push_s      = inflight_q && !bus.REDIRECT;
        occupancy_s = (CW+1)'(count_q) + (CW+1)'(inflight_q) - (CW+1)'(pop_s);
        rden_s      = !RESET && !bus.REDIRECT && (occupancy_s < (CW+1)'(DEPTH));
    end

    // Next-state for queue bookkeeping and the fetch address.
    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        inflight_d = inflight_q;
        req_pc_d   = req_pc_q;
        fetch_pc_d = fetch_pc_q;
        if (bus.REDIRECT) begin
            count_d    = {CW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            inflight_d = 1'b0;
            fetch_pc_d = bus.REDIRECT_PC & {{(XLEN-2){1'b1}}, 2'b00};
        end else begin
            count_d    = count_q + CW'(push_s) - CW'(pop_s);
            rd_ptr_d   = rd_ptr_q + PW'(pop_s);
            wr_ptr_d   = wr_ptr_q + PW'(push_s);
            inflight_d = rden_s;
            if (rden_s) begin
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(32'd4);
            end else begin
                req_pc_d   = req_pc_q;
                fetch_pc_d = fetch_pc_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q    <= {CW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            inflight_q <= 1'b0;
            req_pc_q   <= {XLEN{1'b0}};
            fetch_pc_q <= RESET_PC;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
            req_pc_q   <= req_pc_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Entry storage; contents are never visible unless counted valid, so no reset is needed.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            ir_mem[wr_ptr_q] <= bus.MEM_DOUT1;
            pc_mem[wr_ptr_q] <= req_pc_q;
        end
    end

    assign bus.MEM_RDEN1 = rden_s;
    assign bus.FETCH_PC  = fetch_pc_q;
    assign bus.COUNT     = count_q;
    assign bus.DE_VALID  = (count_q != {CW{1'b0}});
    assign bus.DE_IR     = (count_q != {CW{1'b0}}) ? ir_mem[rd_ptr_q] : 32'h0000_0000;
    assign bus.DE_PC     = (count_q != {CW{1'b0}}) ? pc_mem[rd_ptr_q] : {XLEN{1'b0}};
endmodule
